// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU request sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam logic [1:0] SEL_ARITHMETIC = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_SHIFTER = 2'b11;
  localparam int OP_W = 3;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; a tie goes to the requester not granted last
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last_q;
  assign gnt[0] = req[0] & (~req[1] | last_q);
  assign gnt[1] = req[1] & (~req[0] | ~last_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else if (advance) last_q <= gnt[1];
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: arbitrates two requesters onto the shared ALU, waits LAT cycles, returns a tagged result
module alu_sequencer import alu_seq_pkg::*; #(
  parameter int N = 8,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_0,
  input  logic            req_valid_1,
  output logic            req_ready_0,
  output logic            req_ready_1,
  input  logic [N-1:0]    req_a_0,
  input  logic [N-1:0]    req_a_1,
  input  logic [N-1:0]    req_b_0,
  input  logic [N-1:0]    req_b_1,
  input  logic [1:0]      req_sel_0,
  input  logic [1:0]      req_sel_1,
  input  logic [OP_W-1:0] req_op_0,
  input  logic [OP_W-1:0] req_op_1,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_s1,
  output logic            alu_s0,
  output logic [OP_W-1:0] alu_op,
  input  logic [N-1:0]    alu_rc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [N-1:0]    rsp_data,
  output logic            busy
);
  localparam int CW = $clog2(LAT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] a_q, b_q, rsp_data_q;
  logic [1:0] sel_q;
  logic [OP_W-1:0] op_q;
  logic id_q, rsp_id_q;
  logic [1:0] gnt;
  logic idle, accept, capture;
  rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({req_valid_1, req_valid_0}),
    .advance(accept),
    .gnt(gnt)
  );
  assign idle = state_q == IDLE;
  assign accept = idle & |gnt;
  assign capture = state_q == BUSY && cnt_q == '0;
  // readies are combinational, so mask them while reset is asserted
  assign req_ready_0 = idle & gnt[0] & ~rst;
  assign req_ready_1 = idle & gnt[1] & ~rst;
  always_comb begin
    state_d = accept ? BUSY : capture ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
    cnt_d = accept ? CW'(LAT - 1) : (state_q == BUSY && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      op_q <= '0;
      id_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        a_q <= gnt[1] ? req_a_1 : req_a_0;
        b_q <= gnt[1] ? req_b_1 : req_b_0;
        sel_q <= gnt[1] ? req_sel_1 : req_sel_0;
        op_q <= gnt[1] ? req_op_1 : req_op_0;
        id_q <= gnt[1];
      end
      if (capture) begin
        rsp_data_q <= alu_rc;
        rsp_id_q <= id_q;
      end
    end
  end
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign {alu_s1, alu_s0} = sel_q;
  assign alu_op = op_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign busy = ~idle;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: two sequencers (LAT=1 combinational ALU, LAT=4 pipelined ALU) against a transaction-level model
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  typedef struct {logic id; logic [7:0] d;} rsp_t;
  logic clk = 1'b0;
  logic rst;
  logic rv[2][2], rr[2][2];
  logic [7:0] pa[2][2], pb[2][2];
  logic [1:0] ps[2][2];
  logic [2:0] po[2][2];
  logic [7:0] aa[2], ab[2], rc[2], rd[2];
  logic as1[2], as0[2], rsv[2], rsp_rdy[2], rid[2], bsy[2];
  logic [2:0] aop[2];
  logic [7:0] pipe[3];
  int cyc = 0, nchk = 0, nfail = 0;
  bit acc[2][2];
  bit m_idle[2], m_last[2];
  int m_k[2];
  logic [7:0] m_a[2], m_b[2];
  logic [1:0] m_s[2];
  logic [2:0] m_o[2];
  rsp_t m_exp[2];
  rsp_t sbq0[$], sbq1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [1:0] s, logic [2:0] o);
    if (s == SEL_LOGIC) return o[1:0] == 2'd0 ? a & b : o[1:0] == 2'd1 ? a | b : o[1:0] == 2'd2 ? a ^ b : ~a;
    if (s == SEL_SHIFTER) return o[0] ? a >> b[2:0] : a << b[2:0];
    if (s == SEL_ARITHMETIC || s == 2'b10) return o[0] ? a - b : a + b;
    return 8'hxx;
  endfunction
  function automatic int lat(int i);
    return i == 0 ? 1 : 4;
  endfunction
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[inst %0d] at cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask
  assign rc[0] = alu_f(aa[0], ab[0], {as1[0], as0[0]}, aop[0]);
  always @(posedge clk) begin
    pipe[0] <= alu_f(aa[1], ab[1], {as1[1], as0[1]}, aop[1]);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign rc[1] = pipe[2];
  alu_sequencer #(.N(8), .LAT(1)) u0 (
    .clk(clk), .rst(rst),
    .req_valid_0(rv[0][0]), .req_valid_1(rv[0][1]),
    .req_ready_0(rr[0][0]), .req_ready_1(rr[0][1]),
    .req_a_0(pa[0][0]), .req_a_1(pa[0][1]), .req_b_0(pb[0][0]), .req_b_1(pb[0][1]),
    .req_sel_0(ps[0][0]), .req_sel_1(ps[0][1]), .req_op_0(po[0][0]), .req_op_1(po[0][1]),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_s1(as1[0]), .alu_s0(as0[0]), .alu_op(aop[0]),
    .alu_rc(rc[0]), .rsp_valid(rsv[0]), .rsp_ready(rsp_rdy[0]), .rsp_id(rid[0]),
    .rsp_data(rd[0]), .busy(bsy[0])
  );
  alu_sequencer #(.N(8), .LAT(4)) u1 (
    .clk(clk), .rst(rst),
    .req_valid_0(rv[1][0]), .req_valid_1(rv[1][1]),
    .req_ready_0(rr[1][0]), .req_ready_1(rr[1][1]),
    .req_a_0(pa[1][0]), .req_a_1(pa[1][1]), .req_b_0(pb[1][0]), .req_b_1(pb[1][1]),
    .req_sel_0(ps[1][0]), .req_sel_1(ps[1][1]), .req_op_0(po[1][0]), .req_op_1(po[1][1]),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_s1(as1[1]), .alu_s0(as0[1]), .alu_op(aop[1]),
    .alu_rc(rc[1]), .rsp_valid(rsv[1]), .rsp_ready(rsp_rdy[1]), .rsp_id(rid[1]),
    .rsp_data(rd[1]), .busy(bsy[1])
  );
  // monitor: model holds one outstanding op per instance; scoreboard pops on first response cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0] g;
      rsp_t e;
      if (rst) begin
        m_idle[i] = 1'b1;
        m_last[i] = 1'b1;
        acc[i][0] = 1'b0;
        acc[i][1] = 1'b0;
        if (i == 0) sbq0.delete(); else sbq1.delete();
      end else begin
        acc[i][0] = rv[i][0] & rr[i][0];
        acc[i][1] = rv[i][1] & rr[i][1];
        if (m_idle[i]) begin
          g = (rv[i][0] & rv[i][1]) ? (m_last[i] ? 2'b01 : 2'b10) : {rv[i][1], rv[i][0]};
          chk("req_ready_0", i, rr[i][0], g[0]);
          chk("req_ready_1", i, rr[i][1], g[1]);
          chk("busy_idle", i, bsy[i], 0);
          chk("rsp_valid_idle", i, rsv[i], 0);
          if (g != 2'b00) begin
            m_last[i] = g[1];
            m_idle[i] = 1'b0;
            m_k[i] = cyc + 1;
            m_a[i] = pa[i][g[1]];
            m_b[i] = pb[i][g[1]];
            m_s[i] = ps[i][g[1]];
            m_o[i] = po[i][g[1]];
            e.id = g[1];
            e.d = alu_f(m_a[i], m_b[i], m_s[i], m_o[i]);
            if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
          end
        end else begin
          chk("req_ready_0_busy", i, rr[i][0], 0);
          chk("req_ready_1_busy", i, rr[i][1], 0);
          chk("busy", i, bsy[i], 1);
          if (cyc < m_k[i] + lat(i)) begin
            chk("rsp_valid_early", i, rsv[i], 0);
            chk("alu_a", i, aa[i], m_a[i]);
            chk("alu_b", i, ab[i], m_b[i]);
            chk("alu_sel", i, {as1[i], as0[i]}, m_s[i]);
            chk("alu_op", i, aop[i], m_o[i]);
          end else begin
            chk("rsp_valid", i, rsv[i], 1);
            if (cyc == m_k[i] + lat(i)) begin
              chk("scoreboard_nonempty", i, (i == 0 ? sbq0.size() : sbq1.size()) > 0, 1);
              if (i == 0 && sbq0.size() > 0) m_exp[i] = sbq0.pop_front();
              if (i == 1 && sbq1.size() > 0) m_exp[i] = sbq1.pop_front();
            end
            chk("rsp_data", i, rd[i], m_exp[i].d);
            chk("rsp_id", i, rid[i], m_exp[i].id);
            if (rsp_rdy[i]) m_idle[i] = 1'b1;
          end
        end
      end
    end
  end
  task automatic new_req(input int i, input int r);
    rv[i][r] = 1'b1;
    pa[i][r] = 8'($urandom);
    pb[i][r] = 8'($urandom);
    ps[i][r] = 2'($urandom_range(0, 3));
    po[i][r] = 3'($urandom_range(0, 7));
  endtask
  task automatic drive(input int t);
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (acc[i][r]) rv[i][r] = 1'b0;
        if (!rv[i][r] && $urandom_range(0, 2) == 0) new_req(i, r);
      end
      rsp_rdy[i] = (t >= 40 && t < 45) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  endtask
  initial begin
    int w;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rsp_rdy[i] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        rv[i][r] = 1'b0;
        pa[i][r] = '0;
        pb[i][r] = '0;
        ps[i][r] = '0;
        po[i][r] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rv[0][0] = 1'b1; pa[0][0] = 8'sd5; pb[0][0] = 8'sd3; ps[0][0] = 2'b00; po[0][0] = 3'd0;
    rv[1][0] = 1'b1; pa[1][0] = 8'd10; pb[1][0] = 8'd20; ps[1][0] = 2'b00; po[1][0] = 3'd0;
    rv[1][1] = 1'b1; pa[1][1] = 8'hf9; pb[1][1] = 8'd2; ps[1][1] = 2'b01; po[1][1] = 3'd2;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1 drive(t);
    end
    rsp_rdy[0] = 1'b1;
    rsp_rdy[1] = 1'b1;
    if (!rv[1][0]) new_req(1, 0);
    w = 0;
    do begin
      @(negedge clk);
      #1 w++;
    end while (!(!m_idle[1] && cyc >= m_k[1] && cyc < m_k[1] + 3) && w < 100);
    chk("reach_busy_bound", 1, w < 100, 1);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready_0", i, rr[i][0], 0);
      chk("rst_req_ready_1", i, rr[i][1], 0);
      chk("rst_alu_a", i, aa[i], 0);
      chk("rst_alu_b", i, ab[i], 0);
      chk("rst_alu_sel", i, {as1[i], as0[i]}, 0);
      chk("rst_alu_op", i, aop[i], 0);
      chk("rst_rsp_valid", i, rsv[i], 0);
      chk("rst_rsp_id", i, rid[i], 0);
      chk("rst_rsp_data", i, rd[i], 0);
      chk("rst_busy", i, bsy[i], 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 2; r++)
        if (!rv[i][r]) new_req(i, r);
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1 drive(t);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
